gate_op_arbiter: RTL and testbench

//  Shares one WIDTH-bit bitwise gate unit (AND/OR/XOR/NOT) between N_REQ requesters.
//  - Requesters issue operations over a valid/ready handshake.
//  - A round-robin arbiter selects one request per slot.
//  - The result is registered and returned with the winning requester's ID.
//  - Sits between client blocks and the gate datapath; it is the only driver of that datapath.

---
 rtl/gate_op_arbiter.sv | 76 +++++++
 tb/tb_gate_op_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/gate_op_arbiter.sv
// gate_op_arbiter: round-robin shared bitwise gate unit with registered, handshaked result
module gate_op_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int CNT_W = 16,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*2-1:0]     req_op,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [WIDTH-1:0]       resp_data,
  output logic [ID_W-1:0]        resp_id,
  output logic [CNT_W-1:0]       op_count
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state, state_nx;
  logic [ID_W-1:0] rr_ptr, win;
  logic found, slot_open;
  logic [1:0] op;
  logic [WIDTH-1:0] a, b, res;
  int idx;
  // Round-robin search from rr_ptr; descending scan so the nearest valid requester wins last
  always_comb begin
    slot_open = rst_n && (state == IDLE || resp_ready);
    found = 1'b0;
    win = '0;
    idx = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req_valid[idx]) begin
        found = 1'b1;
        win = ID_W'(idx);
      end
    end
    found = found && slot_open;
  end
  // Grant vector, winner's operands, gate result and next state
  always_comb begin
    req_ready = found ? {{(N_REQ-1){1'b0}}, 1'b1} << win : '0;
    op = req_op[2*win +: 2];
    a = req_a[WIDTH*win +: WIDTH];
    b = req_b[WIDTH*win +: WIDTH];
    res = op == 2'b00 ? a & b : op == 2'b01 ? a | b : op == 2'b10 ? a ^ b : ~a;
    resp_valid = state == HOLD;
    state_nx = found ? HOLD : (state == HOLD && resp_ready) ? IDLE : state;
  end
  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // Capture the winner's result and advance the round-robin pointer past it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_data <= '0;
      resp_id <= '0;
      rr_ptr <= '0;
    end else if (found) begin
      resp_data <= res;
      resp_id <= win;
      rr_ptr <= win == ID_W'(N_REQ - 1) ? '0 : win + 1'b1;
    end
  end
  // Saturating count of handed-off results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) op_count <= '0;
    else if (resp_valid && resp_ready && !(&op_count)) op_count <= op_count + 1'b1;
  end
endmodule

// File: tb/tb_gate_op_arbiter.sv
// tb_gate_op_arbiter: directed scoreboard bench for gate_op_arbiter
module tb_gate_op_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req_valid;
  logic [7:0] req_op;
  logic [31:0] req_a, req_b;
  logic [3:0] req_ready, s_req_ready;
  logic resp_valid, s_resp_valid, resp_ready;
  logic [7:0] resp_data, s_resp_data;
  logic [1:0] resp_id, s_resp_id;
  logic [15:0] op_count;
  logic [3:0] s_op_count;
  logic [9:0] q[$];
  logic [9:0] e;
  logic [7:0] held;
  int n_total = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  gate_op_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op), .req_a(req_a),
    .req_b(req_b), .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id), .op_count(op_count)
  );

  gate_op_arbiter #(.CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op), .req_a(req_a),
    .req_b(req_b), .req_ready(s_req_ready), .resp_valid(s_resp_valid), .resp_ready(resp_ready),
    .resp_data(s_resp_data), .resp_id(s_resp_id), .op_count(s_op_count)
  );

  function automatic logic [7:0] gop(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    case (o)
      2'b00: gop = x & y;
      2'b01: gop = x | y;
      2'b10: gop = x ^ y;
      default: gop = ~x;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_req(input int i, input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    req_op[2*i +: 2] = o;
    req_a[8*i +: 8] = x;
    req_b[8*i +: 8] = y;
  endtask

  task automatic push(input int i);
    q.push_back({2'(i), gop(req_op[2*i +: 2], req_a[8*i +: 8], req_b[8*i +: 8])});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Hand-off monitor: every accepted result is compared against the oldest expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && resp_valid === 1'b1 && resp_ready === 1'b1) begin
      n_total++;
      if (q.size() == 0) begin
        $error("FAIL sb_empty observed=%h expected=none", {resp_id, resp_data});
      end else begin
        e = q.pop_front();
        assert ({resp_id, resp_data} === e) n_pass++;
        else $error("FAIL sb_resp observed=%h expected=%h", {resp_id, resp_data}, e);
      end
    end
  end

  initial begin
    logic [7:0] exp_t2 [4];
    logic [1:0] op_t2 [4];
    exp_t2 = '{8'hCC, 8'h30, 8'hFC, 8'h0F};
    op_t2 = '{2'b10, 2'b00, 2'b01, 2'b11};
    rst_n = 1'b0;
    req_valid = '0;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    resp_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", resp_valid, 0);
    chk("rst_count", op_count, 0);
    chk("rst_data", resp_data, 0);
    rst_n = 1'b1;
    resp_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      set_req(1, op_t2[t], 8'hF0, 8'h3C);
      req_valid = 4'b0010;
      #1;
      chk("single_grant", req_ready, 4'b0010);
      push(1);
      tick();
      req_valid = '0;
      chk("single_data", resp_data, exp_t2[t]);
      chk("single_id", resp_id, 1);
      chk("single_valid", resp_valid, 1);
      tick();
    end
    chk("single_count", op_count, 4);
    req_valid = 4'b1111;
    resp_ready = 1'b0;
    #1;
    tick();
    chk("pre_rst_hold", resp_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", resp_valid, 0);
    chk("async_rst_count", op_count, 0);
    chk("async_rst_ready", req_ready, 0);
    chk("async_rst_count_s", s_op_count, 0);
    tick();
    rst_n = 1'b1;
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 2'(i), 8'h5A + 8'(8'h13 * i), 8'hC3 - 8'(8'h21 * i));
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("fair_grant", req_ready, 4'b0001 << (c % 4));
      push(c % 4);
      tick();
    end
    req_valid = '0;
    tick();
    chk("fair_count", op_count, 6);
    req_valid = 4'b0100;
    resp_ready = 1'b0;
    #1;
    chk("bp_first_grant", req_ready, 4'b0100);
    held = gop(req_op[5:4], req_a[23:16], req_b[23:16]);
    push(2);
    tick();
    req_valid = 4'b1111;
    set_req(2, 2'b10, 8'h81, 8'h18);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_ready", req_ready, 0);
      chk("bp_data", resp_data, held);
      chk("bp_id", resp_id, 2);
      tick();
    end
    resp_ready = 1'b1;
    #1;
    chk("bp_release_grant", req_ready, 4'b1000);
    push(3);
    tick();
    req_valid = '0;
    tick();
    chk("bp_count", op_count, 8);
    req_valid = 4'b0100;
    #1;
    chk("wrap_set_ptr", req_ready, 4'b0100);
    push(2);
    tick();
    req_valid = '0;
    tick();
    for (int c = 0; c < 3; c++) begin
      chk("idle_ready", req_ready, 0);
      tick();
    end
    chk("idle_valid", resp_valid, 0);
    req_valid = 4'b1010;
    #1;
    chk("wrap_grant3", req_ready, 4'b1000);
    push(3);
    tick();
    chk("wrap_grant1", req_ready, 4'b0010);
    push(1);
    tick();
    req_valid = '0;
    tick();
    chk("wrap_count", op_count, 11);
    req_valid = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      #1;
      chk("sat_grant", req_ready, 4'b0001 << ((c + 2) % 4));
      push((c + 2) % 4);
      tick();
    end
    req_valid = '0;
    tick();
    chk("sat_count_s", s_op_count, 4'hF);
    chk("sat_count_wide", op_count, 31);
    tick();
    chk("sat_hold_s", s_op_count, 4'hF);
    chk("sb_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
